// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle MIPS MULT/MULTU/DIV/DIVU engine producing {hi, lo}.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int MULT_LATENCY = 2,
  parameter int DIV_ITERS    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        w_sgn_in;
  logic [31:0] w_abs_a, w_abs_b;
  logic [31:0] w_ma, w_mb;
  logic        w_msgn;
  logic [63:0] w_ea, w_eb, w_prod;
  logic [32:0] w_rem_sh, w_trial;

  assign w_sgn_in = ~op[0];
  assign w_abs_a  = (w_sgn_in && a[31]) ? -a : a;
  assign w_abs_b  = (w_sgn_in && b[31]) ? -b : b;

  // In IDLE the multiplier sees the raw inputs so a latency-1 MULT can finish
  // on the launch edge; otherwise it works from the latched operands.
  assign w_ma   = (state_q == S_IDLE) ? a : a_q;
  assign w_mb   = (state_q == S_IDLE) ? b : b_q;
  assign w_msgn = (state_q == S_IDLE) ? w_sgn_in : sgn_q;
  assign w_ea   = {{32{w_msgn & w_ma[31]}}, w_ma};
  assign w_eb   = {{32{w_msgn & w_mb[31]}}, w_mb};
  assign w_prod = w_ea * w_eb;

  // a_q doubles as dividend shift-out / quotient shift-in register.
  assign w_rem_sh = {rem_q, a_q[31]};
  assign w_trial  = w_rem_sh - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          sgn_d = w_sgn_in;
          if (!op[1]) begin
            a_d = a;
            b_d = b;
            if (MULT_LATENCY <= 1) begin
              state_d      = S_DONE;
              {hi_d, lo_d} = w_prod;
            end else begin
              state_d = S_MUL;
              cnt_d   = 6'(MULT_LATENCY - 1);
            end
          end else begin
            a_d     = w_abs_a;
            b_d     = w_abs_b;
            rem_d   = '0;
            negq_d  = w_sgn_in & (a[31] ^ b[31]);
            negr_d  = w_sgn_in & a[31];
            cnt_d   = 6'(DIV_ITERS);
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'd1) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = w_prod;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!w_trial[32]) begin
            rem_d = w_trial[31:0];
            a_d   = {a_q[30:0], 1'b1};
          end else begin
            rem_d = w_rem_sh[31:0];
            a_d   = {a_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = negq_q ? -a_q : a_q;
          hi_d    = negr_q ? -rem_q : rem_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] ph, pl;
  int pulses;

  muldiv_unit #(.MULT_LATENCY(2), .DIV_ITERS(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an op for cycle 0; returns at cycle 1 with start low.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called at cycle 1; walks to the done cycle and checks the result.
  task automatic finish_op(input string tag, input int lat, input logic [31:0] eh, input logic [31:0] el);
    for (int c = 1; c < lat; c++) begin
      chk({tag, "_busy"}, {62'd0, busy, done}, 64'd2);
      if (c == lat - 1) chk({tag, "_hold"}, {hi, lo}, {ph, pl});
      tick();
    end
    chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
    chk({tag, "_res"}, {hi, lo}, {eh, el});
    ph = eh; pl = el;
    tick();
    chk({tag, "_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    ph = '0; pl = '0;
    tick(); tick();
    chk("reset", {busy, done, hi, lo}, 66'd0);
    resetn = 1'b1;
    tick();

    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    finish_op("mult_neg", 2, 32'hFFFFFFFF, 32'hFFFFFFEB);

    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    finish_op("multu_max", 2, 32'hFFFFFFFE, 32'h00000001);

    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    finish_op("div_m7_2", 34, 32'hFFFFFFFF, 32'hFFFFFFFD);

    launch(2'b11, 32'd100, 32'd0);
    finish_op("divu_by0", 34, 32'h00000064, 32'hFFFFFFFF);

    launch(2'b10, 32'hFFFFFF9C, 32'd0);
    finish_op("div_neg_by0", 34, 32'hFFFFFF9C, 32'h00000001);

    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div_ovf", 34, 32'h00000000, 32'h80000000);

    launch(2'b10, 32'd100, 32'hFFFFFFF9);
    finish_op("div_100_m7", 34, 32'h00000002, 32'hFFFFFFF2);

    // Flush at cycle 10 of a divide.
    launch(2'b10, 32'd50, 32'd3);
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'd0, busy, done}, 64'd0);
    chk("flush_hold", {hi, lo}, {ph, pl});
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) pulses++;
      tick();
    end
    chk("flush_nodone", 64'(pulses), 64'd0);

    // Second start at cycle 5 must not disturb the running divide.
    launch(2'b10, 32'd1000, 32'd7);
    for (int c = 1; c < 34; c++) begin
      if (c == 5) begin
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("restart_done", {62'd0, busy, done}, 64'd1);
    chk("restart_res", {hi, lo}, {32'd6, 32'h0000008E});
    ph = 32'd6; pl = 32'h0000008E;
    tick();

    // Start presented in the DONE cycle is dropped.
    launch(2'b01, 32'd5, 32'd6);
    tick();
    chk("done_cycle", {62'd0, busy, done}, 64'd1);
    chk("mult_small", {hi, lo}, {32'd0, 32'd30});
    ph = 32'd0; pl = 32'd30;
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ign", {62'd0, busy, done}, 64'd0);
    tick();
    chk("done_start_ign2", {62'd0, busy, done}, 64'd0);

    // Flush wins over start in IDLE.
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {62'd0, busy, done}, 64'd0);
    tick();
    chk("flush_start2", {62'd0, busy, done, hi, lo}, {64'd0, ph, pl});

    // Asynchronous reset in the middle of a divide.
    launch(2'b10, 32'd77, 32'd5);
    for (int c = 1; c < 10; c++) tick();
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst", {busy, done, hi, lo}, 66'd0);
    tick();
    resetn = 1'b1;
    ph = '0; pl = '0;
    tick();

    launch(2'b11, 32'd77, 32'd5);
    finish_op("divu_post_rst", 34, 32'd2, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
